// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: widths, tag/opcode encodings and FSM states shared by the ALU execution unit.
package alu_exec_pkg;
   localparam int XLEN    = 32;
   localparam int TAG_W   = 4;
   localparam int OP_W    = 5;
   localparam int REG_W   = 5;
   localparam int SHAMT_W = $clog2(XLEN);
   localparam logic [TAG_W-1:0] UNLOCKED = '1;
   localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
   localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
   localparam logic [OP_W-1:0] OP_SLT   = 5'd2;
   localparam logic [OP_W-1:0] OP_SLTU  = 5'd3;
   localparam logic [OP_W-1:0] OP_XOR   = 5'd4;
   localparam logic [OP_W-1:0] OP_OR    = 5'd5;
   localparam logic [OP_W-1:0] OP_AND   = 5'd6;
   localparam logic [OP_W-1:0] OP_SLL   = 5'd7;
   localparam logic [OP_W-1:0] OP_SRL   = 5'd8;
   localparam logic [OP_W-1:0] OP_SRA   = 5'd9;
   localparam logic [OP_W-1:0] OP_LUI   = 5'd10;
   localparam logic [OP_W-1:0] OP_AUIPC = 5'd11;
   localparam logic [OP_W-1:0] OP_JAL   = 5'd12;
   localparam logic [OP_W-1:0] OP_JALR  = 5'd13;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_BCAST} state_t;
endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: one-bit-per-cycle shifter; i_start loads operand and amount, o_done when the count is exhausted.
module alu_shift_iter
   import alu_exec_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic               i_step,
   input  logic               i_left,
   input  logic               i_arith,
   input  logic [XLEN-1:0]    i_data,
   input  logic [SHAMT_W-1:0] i_shamt,
   output logic               o_done,
   output logic [XLEN-1:0]    o_result
);
   logic [SHAMT_W-1:0] r_cnt;
   logic [XLEN-1:0]    r_acc;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (i_start) begin
         r_cnt <= i_shamt;
         r_acc <= i_data;
      end else if (i_step && r_cnt != '0) begin
         r_cnt <= r_cnt - SHAMT_W'(1);
         r_acc <= i_left ? {r_acc[XLEN-2:0], 1'b0} : {i_arith & r_acc[XLEN-1], r_acc[XLEN-1:1]};
      end
   end
   assign o_done   = r_cnt == '0;
   assign o_result = r_acc;
endmodule

// File: rtl/alu_exec.sv
// alu_exec: consumes one ALU reservation-station slot, executes once operands are ready and broadcasts on the CDB.
module alu_exec
   import alu_exec_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             slot_busy,
   input  logic [OP_W-1:0]  slot_op,
   input  logic [TAG_W-1:0] slot_tagx,
   input  logic [TAG_W-1:0] slot_tagy,
   input  logic [TAG_W-1:0] slot_tagw,
   input  logic [XLEN-1:0]  slot_datax,
   input  logic [XLEN-1:0]  slot_datay,
   input  logic [REG_W-1:0] slot_target,
   input  logic [XLEN-1:0]  slot_pc,
   output logic             busy_out,
   output logic             cdb_req,
   input  logic             cdb_gnt,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [REG_W-1:0] cdb_target,
   output logic [XLEN-1:0]  cdb_data
);
   state_t           r_state, w_next;
   logic [OP_W-1:0]  r_op;
   logic [XLEN-1:0]  r_x, r_y, r_pc, w_alu, w_sh_res;
   logic [TAG_W-1:0] r_tagw;
   logic [REG_W-1:0] r_tgt;
   logic             w_ready, w_is_shift, w_sh_done, w_start;
   assign w_ready    = slot_tagx == UNLOCKED && slot_tagy == UNLOCKED;
   assign w_is_shift = r_op inside {OP_SLL, OP_SRL, OP_SRA};
   assign w_start    = rdy && r_state == S_WAIT && w_next == S_EXEC;
   assign busy_out   = r_state != S_IDLE;
   assign cdb_req    = r_state == S_BCAST;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = slot_busy ? S_WAIT : S_IDLE;
         S_WAIT:  w_next = !slot_busy ? S_IDLE : (w_ready ? S_EXEC : S_WAIT);
         S_EXEC:  w_next = (!w_is_shift || w_sh_done) ? S_BCAST : S_EXEC;
         S_BCAST: w_next = cdb_gnt ? S_IDLE : S_BCAST;
         default: w_next = S_IDLE;
      endcase
   end
   always_comb begin
      w_alu = '0;
      case (r_op)
         OP_ADD:   w_alu = r_x + r_y;
         OP_SUB:   w_alu = r_x - r_y;
         OP_SLT:   w_alu = XLEN'($signed(r_x) < $signed(r_y));
         OP_SLTU:  w_alu = XLEN'(r_x < r_y);
         OP_XOR:   w_alu = r_x ^ r_y;
         OP_OR:    w_alu = r_x | r_y;
         OP_AND:   w_alu = r_x & r_y;
         OP_LUI:   w_alu = r_y;
         OP_AUIPC: w_alu = r_pc + r_y;
         OP_JAL:   w_alu = r_pc + XLEN'(4);
         OP_JALR:  w_alu = r_pc + XLEN'(4);
         default:  w_alu = '0;
      endcase
   end
   alu_shift_iter u_shift (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_start),
      .i_step   (rdy && r_state == S_EXEC),
      .i_left   (r_op == OP_SLL),
      .i_arith  (r_op == OP_SRA),
      .i_data   (slot_datax),
      .i_shamt  (slot_datay[SHAMT_W-1:0]),
      .o_done   (w_sh_done),
      .o_result (w_sh_res)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_pc       <= '0;
         r_tagw     <= UNLOCKED;
         r_tgt      <= '0;
         cdb_tag    <= UNLOCKED;
         cdb_target <= '0;
         cdb_data   <= '0;
      end else if (rdy) begin
         r_state <= w_next;
         if (w_start) begin
            r_op   <= slot_op;
            r_x    <= slot_datax;
            r_y    <= slot_datay;
            r_pc   <= slot_pc;
            r_tagw <= slot_tagw;
            r_tgt  <= slot_target;
         end
         // broadcast fields are frozen for the whole BCAST stay
         if (r_state == S_EXEC && w_next == S_BCAST) begin
            cdb_tag    <= r_tagw;
            cdb_target <= r_tgt;
            cdb_data   <= w_is_shift ? w_sh_res : w_alu;
         end
      end
   end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vectors with a scoreboard queue checked by an independent CDB monitor.
module tb_alu_exec;
   import alu_exec_pkg::*;
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [REG_W-1:0] tgt;
      logic [XLEN-1:0]  data;
   } exp_t;
   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rdy = 1'b1;
   logic             slot_busy = 1'b0;
   logic [OP_W-1:0]  slot_op = '0;
   logic [TAG_W-1:0] slot_tagx = UNLOCKED;
   logic [TAG_W-1:0] slot_tagy = UNLOCKED;
   logic [TAG_W-1:0] slot_tagw = '0;
   logic [XLEN-1:0]  slot_datax = '0;
   logic [XLEN-1:0]  slot_datay = '0;
   logic [REG_W-1:0] slot_target = '0;
   logic [XLEN-1:0]  slot_pc = '0;
   logic             cdb_gnt = 1'b0;
   logic             busy_out, cdb_req;
   logic [TAG_W-1:0] cdb_tag;
   logic [REG_W-1:0] cdb_target;
   logic [XLEN-1:0]  cdb_data;
   int               tests = 0;
   int               fails = 0;
   exp_t             sb[$];
   exp_t             mon_e;
   always #5 clk = ~clk;
   alu_exec dut (
      .clk(clk), .rst(rst), .rdy(rdy), .slot_busy(slot_busy), .slot_op(slot_op),
      .slot_tagx(slot_tagx), .slot_tagy(slot_tagy), .slot_tagw(slot_tagw),
      .slot_datax(slot_datax), .slot_datay(slot_datay), .slot_target(slot_target),
      .slot_pc(slot_pc), .busy_out(busy_out), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
      .cdb_tag(cdb_tag), .cdb_target(cdb_target), .cdb_data(cdb_data)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rst && rdy && cdb_req && cdb_gnt) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_bcast: got tag %0h target %0h data %0h expected none", cdb_tag, cdb_target, cdb_data);
         end else begin
            mon_e = sb.pop_front();
            chk("bcast", {cdb_tag, cdb_target, cdb_data}, mon_e);
         end
      end
   end
   task automatic run(input logic [OP_W-1:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                      input logic [XLEN-1:0] pc, input logic [TAG_W-1:0] tw, input logic [REG_W-1:0] tg,
                      input logic [XLEN-1:0] exp, input int exp_lat, input int wait_cyc = 0,
                      input int gnt_delay = 0, input int stall_at = -1, input int stall_len = 0);
      int n = 0;
      sb.push_back('{tag: tw, tgt: tg, data: exp});
      slot_op = op; slot_datay = y; slot_pc = pc; slot_tagw = tw; slot_target = tg;
      slot_tagy = UNLOCKED;
      slot_tagx = wait_cyc > 0 ? 4'd2 : UNLOCKED;
      slot_datax = wait_cyc > 0 ? 32'hDEAD_BEEF : x;
      slot_busy = 1'b1;
      cdb_gnt = gnt_delay == 0;
      repeat (wait_cyc) begin @(posedge clk); #1; n++; end
      slot_tagx = UNLOCKED; slot_datax = x;
      while (!cdb_req && n < 200) begin
         if (n == stall_at) rdy = 1'b0;
         @(posedge clk); #1; n++;
         if (stall_at >= 0 && n == stall_at + stall_len) begin
            chk("stall_busy", busy_out, 1);
            rdy = 1'b1;
         end
      end
      chk("latency", n, exp_lat);
      repeat (gnt_delay) begin
         @(posedge clk); #1;
         chk("hold_req_busy", {cdb_req, busy_out}, 2'b11);
         chk("hold_data", cdb_data, exp);
      end
      cdb_gnt = 1'b1;
      @(posedge clk); #1;
      chk("release", {busy_out, cdb_req}, 2'b00);
      slot_busy = 1'b0; cdb_gnt = 1'b0;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      #12;
      chk("reset_ctl", {busy_out, cdb_req}, 2'b00);
      chk("reset_cdb", {cdb_tag, cdb_target, cdb_data}, {UNLOCKED, 5'd0, 32'd0});
      rst = 1'b1;
      @(posedge clk); #1;
      run(OP_ADD,   32'd5,         32'hFFFF_FFFE, 32'd0,         4'd3, 5'd7,  32'd3,         3);
      run(OP_SUB,   32'd3,         32'd5,         32'd0,         4'd1, 5'd2,  32'hFFFF_FFFE, 3);
      run(OP_SLT,   32'h8000_0000, 32'd1,         32'd0,         4'd4, 5'd9,  32'd1,         6, 4);
      run(OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         4'd5, 5'd10, 32'd0,         3);
      run(OP_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         4'd6, 5'd11, 32'h0FF0_0FF0, 3);
      run(OP_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         4'd7, 5'd12, 32'hFFF0_FFF0, 3);
      run(OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         4'd8, 5'd13, 32'hF000_F000, 3);
      run(OP_LUI,   32'd0,         32'hABCD_E000, 32'd0,         4'd9, 5'd14, 32'hABCD_E000, 3);
      run(OP_AUIPC, 32'd0,         32'h0000_2000, 32'h0000_1000, 4'd0, 5'd15, 32'h0000_3000, 3);
      run(OP_JAL,   32'd0,         32'd0,         32'hFFFF_FFFC, 4'd2, 5'd1,  32'd0,         3);
      run(OP_JALR,  32'd9,         32'd9,         32'h0000_0100, 4'd3, 5'd31, 32'h0000_0104, 3);
      run(OP_SRA,   32'h8000_0000, 32'd31,        32'd0,         4'd4, 5'd3,  32'hFFFF_FFFF, 34);
      run(OP_SRL,   32'h8000_0000, 32'd4,         32'd0,         4'd5, 5'd4,  32'h0800_0000, 7);
      run(OP_SLL,   32'h1234_5678, 32'h20,        32'd0,         4'd6, 5'd5,  32'h1234_5678, 3);
      run(OP_SLL,   32'd1,         32'd3,         32'd0,         4'd7, 5'd6,  32'd8,         11, 0, 0, 3, 5);
      run(5'd31,    32'd7,         32'd9,         32'd0,         4'd8, 5'd0,  32'd0,         3);
      run(OP_ADD,   32'h7FFF_FFFF, 32'd1,         32'd0,         4'd9, 5'd8,  32'h8000_0000, 3, 0, 10);
      // flush while waiting for operands: no broadcast may follow
      slot_op = OP_ADD; slot_tagx = 4'd2; slot_busy = 1'b1; cdb_gnt = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      slot_busy = 1'b0;
      @(posedge clk); #1;
      chk("flush_idle", busy_out, 0);
      repeat (4) begin @(posedge clk); #1; chk("flush_noreq", cdb_req, 0); end
      cdb_gnt = 1'b0; slot_tagx = UNLOCKED;
      // asynchronous reset while holding an ungranted broadcast
      slot_op = OP_ADD; slot_datax = 32'd1; slot_datay = 32'd1; slot_tagw = 4'd1; slot_target = 5'd1;
      slot_busy = 1'b1;
      begin
         int n = 0;
         while (!cdb_req && n < 20) begin @(posedge clk); #1; n++; end
         chk("rst_pre_lat", n, 3);
      end
      #2 rst = 1'b0;
      #1;
      chk("rst_async_ctl", {busy_out, cdb_req}, 2'b00);
      chk("rst_async_cdb", {cdb_tag, cdb_data}, {UNLOCKED, 32'd0});
      slot_busy = 1'b0;
      #3 rst = 1'b1;
      cdb_gnt = 1'b1;
      repeat (5) begin @(posedge clk); #1; chk("rst_noreq", cdb_req, 0); end
      cdb_gnt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution unit at the consuming end of one ALU reservation-station slot.
- Watches the slot's busy/op/tag/data outputs and waits until both source tags read UNLOCKED, then computes the result.
- Requests the common data bus (CDB) and broadcasts {tag_w, target, result}.
- Drives busy_out, which the station copies into its busy bit, so the slot is freed exactly when the broadcast is granted.

Parameters:
- XLEN, 32, operand/result width
- TAG_W, 4, register-tag width; value {TAG_W{1'b1}} = UNLOCKED
- OP_W, 5, sinst opcode width
- REG_W, 5, architectural register address width

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- rdy  in  1  global stall; when 0, no state changes
- slot_busy  in  1  station slot holds a valid instruction
- slot_op  in  OP_W  operation
- slot_tagx  in  TAG_W  source-x tag (UNLOCKED = data valid)
- slot_tagy  in  TAG_W  source-y tag
- slot_tagw  in  TAG_W  destination tag
- slot_datax  in  XLEN  source-x value
- slot_datay  in  XLEN  source-y value
- slot_target  in  REG_W  destination register
- slot_pc  in  XLEN  instruction pc (AUIPC/JAL/JALR)
- busy_out  out  1  unit owns an instruction; station keeps slot while 1
- cdb_req  out  1  broadcast request
- cdb_gnt  in  1  grant from CDB arbiter, same-cycle
- cdb_tag  out  TAG_W  broadcast tag
- cdb_target  out  REG_W  broadcast register
- cdb_data  out  XLEN  broadcast result

Behaviour:
- Reset values:
  - state=IDLE, busy_out=0, cdb_req=0.
  - cdb_tag=UNLOCKED, cdb_target=0, cdb_data=0.
  - Shift counter and shift accumulator = 0.
  - Reset mid-operation discards the in-flight instruction; no broadcast follows.
- FSM, advancing only when rdy=1:
  - IDLE: if slot_busy, go to WAIT. busy_out stays 1 from WAIT through BCAST inclusive.
  - WAIT: if slot_tagx==UNLOCKED and slot_tagy==UNLOCKED, latch op, datax, datay, tagw, target and pc, then go to EXEC. Otherwise stay in WAIT (the station snoops the CDB and updates its tags).
  - EXEC, single-cycle ops (ADD SUB SLT SLTU XOR OR AND LUI AUIPC JAL JALR): compute into cdb_data, then go to BCAST.
  - EXEC, shift ops (SLL SRL SRA), iterative, 1 bit per cycle:
    - shamt = datay[4:0].
    - Load the accumulator with datax and the counter with shamt.
    - Each cycle: shift by 1, decrement the counter.
    - Go to BCAST when the counter reaches 0. shamt=0 takes 1 EXEC cycle; shamt=31 takes 32.
    - SRA replicates bit XLEN-1.
  - BCAST: cdb_req=1 with stable cdb_tag/target/data.
    - On cdb_gnt=1: busy_out=0 in the following cycle, state=IDLE.
    - Without grant: hold indefinitely; outputs must not change.
- Operation results:
  - ADD/SUB: modulo 2^XLEN.
  - SLT: signed compare, result 0/1 zero-extended. SLTU: unsigned.
  - LUI: result = datay. AUIPC: result = pc+datay.
  - JAL/JALR: result = pc+4 (link value only; the target address is not computed here).
  - Undefined op: result 0, broadcast still occurs.
- Latency:
  - Minimum slot_busy-with-ready-tags to cdb_req is 3 cycles (IDLE→WAIT→EXEC→BCAST).
  - Back-to-back instructions: IDLE is re-entered after a grant; a new slot_busy is accepted the next cycle.
- Boundary cases:
  - If slot_busy drops while in WAIT (station flush), return to IDLE with no broadcast. This is not checked in EXEC/BCAST.
  - If a grant arrives in the same cycle the station asserts a new instruction, the new one is seen only after IDLE.
  - rdy=0 freezes the FSM, counters and outputs, including cdb_req.
  - If the destination target is 0, the result is still broadcast; the register file discards the write.

Decomposition:
- Shared package/header holds: XLEN, TAG_W, UNLOCKED, OP_W, REG_W, sinst op encodings (OP_ADD … OP_JALR), and FSM state encodings.
- One sub-module, alu_shift_iter: an iterative shifter with start/done handshake, holding the counter and accumulator.
- Combinational op decode stays in alu_exec.

Test Plan:
- Reset: rst=0 mid-BCAST → cdb_req=0 and busy_out=0 immediately (asynchronous); no broadcast after release.
- Ready ADD: datax=5, datay=0xFFFFFFFE, tags UNLOCKED, tagw=3, target=7, cdb_gnt tied 1 → cdb_req on cycle 3 with data 3, tag 3, target 7; busy_out falls on cycle 4.
- Operand wait: tagx=2 for 4 cycles then UNLOCKED with datax=0x80000000; op SLT, datay=1 → broadcast data 1.
- Shift: SRA datax=0x80000000, datay=31 → 32 EXEC cycles, then data 0xFFFFFFFF. SLL with shamt=0 → 1 EXEC cycle, data = datax.
- Grant stall: cdb_gnt=0 for 10 cycles in BCAST → cdb_req and data stable, busy_out=1 throughout; gnt=1 → release next cycle.
- Flush and stall: slot_busy drops in WAIT → IDLE with no cdb_req. rdy=0 during EXEC of a shift → counter frozen, total EXEC cycles = shamt+1 + stall cycles.
